// File: rtl/branch_pc_unit.sv
// rtl/branch_pc_unit.sv - program counter with branch, call/return stack and sticky stack error
module branch_pc_unit #(
    parameter int PC_WIDTH    = 8,
    parameter int PC_STEP     = 1,
    parameter int STACK_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                br_valid,
    input  logic                br_result,
    input  logic [PC_WIDTH-1:0] br_target,
    input  logic                call,
    input  logic                ret,
    input  logic                err_clr,
    output logic [PC_WIDTH-1:0] pc,
    output logic                taken,
    output logic                stack_full,
    output logic                stack_empty,
    output logic                stack_err
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [SP_W-1:0]     sp;
    logic [SP_W-1:0]     sp_dec;
    logic [IDX_W-1:0]    push_idx;
    logic [IDX_W-1:0]    pop_idx;
    logic [PC_WIDTH-1:0] pc_seq;
    logic [PC_WIDTH-1:0] pc_next;
    logic                ret_ok;
    logic                call_ok;
    logic                br_ok;
    logic                err_set;

    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    assign sp_dec      = sp - SP_W'(1);
    assign push_idx    = IDX_W'(sp);
    assign pop_idx     = IDX_W'(sp_dec);
    assign pc_seq      = pc + PC_WIDTH'(PC_STEP);

    // A failed ret or call falls through to the next lower-priority action.
    always_comb begin
        ret_ok  = enable && ret && !stack_empty;
        call_ok = enable && call && !stack_full && !ret_ok;
        br_ok   = enable && br_valid && br_result && !ret_ok && !call_ok;
        err_set = enable && ((ret && stack_empty) || (call && stack_full && !ret_ok));
        pc_next = pc_seq;
        if (ret_ok) begin
            pc_next = stack_mem[pop_idx];
        end else if (call_ok || br_ok) begin
            pc_next = br_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= '0;
            taken     <= 1'b0;
            sp        <= '0;
            stack_err <= 1'b0;
        end else begin
            taken <= ret_ok || call_ok || br_ok;
            if (enable) begin
                pc <= pc_next;
            end
            if (ret_ok) begin
                sp <= sp_dec;
            end else if (call_ok) begin
                sp <= sp + SP_W'(1);
            end
            if (err_set) begin
                stack_err <= 1'b1;
            end else if (err_clr) begin
                stack_err <= 1'b0;
            end
        end
    end

    // Entries are only readable below the pointer, so they need no reset.
    always_ff @(posedge clk) begin
        if (call_ok) begin
            stack_mem[push_idx] <= pc_seq;
        end
    end
endmodule

// File: doc/branch_pc_unit.md
BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 8, meaning program counter and target width in bits.
REQ-002 The block SHALL have parameter PC_STEP, default 1, meaning the increment applied on a sequential advance.
REQ-003 The block SHALL have parameter STACK_DEPTH, default 4, meaning the number of return-address entries.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port enable, input, 1 bit; 1 = advance one instruction this cycle.
REQ-007 The block SHALL have port br_valid, input, 1 bit; 1 = the current instruction is a conditional branch.
REQ-008 The block SHALL have port br_result, input, 1 bit, the condition-checker result (1 = condition true).
REQ-009 The block SHALL have port br_target, input, PC_WIDTH bits, the jump destination for branch and call.
REQ-010 The block SHALL have port call, input, 1 bit; 1 = push the return address and jump to br_target.
REQ-011 The block SHALL have port ret, input, 1 bit; 1 = pop the return address into pc.
REQ-012 The block SHALL have port err_clr, input, 1 bit, synchronous clear of stack_err.
REQ-013 The block SHALL have port pc, output, PC_WIDTH bits, the registered current instruction address.
REQ-014 The block SHALL have port taken, output, 1 bit, a registered one-cycle pulse after any non-sequential pc update.
REQ-015 The block SHALL have ports stack_full and stack_empty, outputs, 1 bit each, combinational from the stack pointer.
REQ-016 The block SHALL have port stack_err, output, 1 bit, sticky overflow/underflow flag.

Function
REQ-017 With enable=0, the block SHALL hold pc, the stack and the stack pointer, and SHALL drive taken=0 on the next edge; all other control inputs are ignored.
REQ-018 With enable=1, the next-pc selection SHALL use this fixed priority: ret, then call, then (br_valid and br_result), then sequential.
REQ-019 Sequential advance SHALL set pc = pc + PC_STEP modulo 2^PC_WIDTH (255 + 1 wraps to 0 at default width).
REQ-020 A taken branch (br_valid=1, br_result=1, no call/ret) SHALL set pc = br_target and taken=1; br_valid=1 with br_result=0 SHALL advance sequentially with taken=0.
REQ-021 A call when not full SHALL push (pc + PC_STEP) modulo 2^PC_WIDTH, increment the stack pointer, set pc = br_target and set taken=1.
REQ-022 A ret when not empty SHALL decrement the stack pointer, set pc to the popped entry and set taken=1.
REQ-023 A call when full SHALL push nothing, set stack_err=1, then fall through to the branch/sequential decision for that cycle.
REQ-024 A ret when empty SHALL pop nothing, set stack_err=1, then fall through to the call/branch/sequential decision for that cycle.
REQ-025 With call=1 and ret=1 together and the stack not empty, only the ret SHALL execute; the call is dropped and SHALL NOT flag an error.
REQ-026 The stack SHALL be LIFO; stack_full = (pointer == STACK_DEPTH); stack_empty = (pointer == 0).
REQ-027 stack_err SHALL stay 1 until reset or err_clr=1; if err_clr=1 and a new error occur in the same cycle, the set SHALL win.
REQ-028 err_clr SHALL act regardless of enable.
REQ-029 taken SHALL be exactly one cycle wide per jump; back-to-back jumps SHALL keep taken=1 on consecutive cycles.

Reset
REQ-030 rst_n=0 SHALL immediately, without waiting for a clock edge, force pc=0, taken=0, stack pointer=0 (stack_empty=1, stack_full=0) and stack_err=0.
REQ-031 Stack entry contents need not be reset, but an entry SHALL never be observable until it has been pushed.
REQ-032 Reset asserted mid-operation SHALL discard all pending stack contents; the first enabled edge after release SHALL advance from pc=0.

Verification
REQ-033 Reset release, then enable=1 for 3 cycles with no control inputs -> pc goes 0, 1, 2, 3; taken stays 0.
REQ-034 pc=5, br_valid=1, br_result=1, br_target=0x40 -> pc=0x40 and taken=1 for one cycle; repeat with br_result=0 -> pc=6 and taken=0.
REQ-035 pc=0x10, call with br_target=0x80, then ret at pc=0x85 -> pc=0x80, then pc=0x11; stack_empty returns to 1.
REQ-036 Five calls with no ret (depth 4) -> stack_full=1 after the 4th call; the 5th call sets stack_err=1 and pc continues sequentially; err_clr=1 -> stack_err=0.
REQ-037 ret on an empty stack at pc=0xFF -> stack_err=1, pc=0x00 (wrap), taken=0.
REQ-038 rst_n pulsed low between clock edges with 2 entries stacked -> pc=0 and stack_empty=1 immediately; a subsequent ret flags stack_err.
